pipe_stage_reg: RTL

Parametrised inter-stage pipeline register with a valid/ready handshake, synchronous flush and an optional two-entry skid buffer. It generalises the fixed-width IF/ID register: any payload width, back-pressure instead of a bare stall input, and a configurable bubble value. It sits between any two stages of the pipeline CPU (IF/ID, ID/EX, EX/MEM, MEM/WB) and carries one payload word per transfer.

---
 rtl/pipe_stage_reg.sv | 132 +++++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised inter-stage register with valid/ready handshake.
// Define PIPE_STAGE_SKID_EN for the two-entry skid variant with a registered in_ready.
module pipe_stage_reg #(
  parameter int                 DATA_W     = 64,
  parameter logic [DATA_W-1:0]  FLUSH_DATA = '0,
  parameter int                 CNT_W      = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic              in_fire;
  logic              out_fire;
  logic [DATA_W-1:0] main_q;
  logic [CNT_W-1:0]  stall_cnt_q;

  assign in_fire  = in_valid & in_ready;
  assign out_fire = out_valid & out_ready;
  assign out_data = out_valid ? main_q : FLUSH_DATA;

`ifdef PIPE_STAGE_SKID_EN

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t            state_q;
  logic [DATA_W-1:0] skid_q;
  logic              in_ready_q;

  assign in_ready  = in_ready_q;
  assign out_valid = (state_q != EMPTY);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= EMPTY;
      main_q     <= FLUSH_DATA;
      skid_q     <= FLUSH_DATA;
      in_ready_q <= 1'b1;
    end else if (flush) begin
      state_q    <= EMPTY;
      main_q     <= FLUSH_DATA;
      skid_q     <= FLUSH_DATA;
      in_ready_q <= 1'b1;
    end else begin
      case (state_q)
        EMPTY: begin
          if (in_fire) begin
            state_q <= ONE;
            main_q  <= in_data;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            main_q <= in_data;
          end else if (in_fire) begin
            // Downstream stalled: park the new item, close the gate next cycle
            state_q    <= FULL;
            skid_q     <= in_data;
            in_ready_q <= 1'b0;
          end else if (out_fire) begin
            state_q <= EMPTY;
            main_q  <= FLUSH_DATA;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_q    <= ONE;
            main_q     <= skid_q;
            skid_q     <= FLUSH_DATA;
            in_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q    <= EMPTY;
          main_q     <= FLUSH_DATA;
          skid_q     <= FLUSH_DATA;
          in_ready_q <= 1'b1;
        end
      endcase
    end
  end

`else

  logic valid_q;

  assign out_valid = valid_q;
  assign in_ready  = !valid_q | out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      main_q  <= FLUSH_DATA;
    end else if (flush) begin
      valid_q <= 1'b0;
      main_q  <= FLUSH_DATA;
    end else if (in_fire) begin
      valid_q <= 1'b1;
      main_q  <= in_data;
    end else if (out_fire) begin
      valid_q <= 1'b0;
      main_q  <= FLUSH_DATA;
    end
  end

`endif

  // Back-pressure statistic keeps counting through flushes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stall_cnt_q <= '0;
    end else if (out_valid && !out_ready && stall_cnt_q != CNT_MAX) begin
      stall_cnt_q <= stall_cnt_q + 1'b1;
    end
  end

  assign stall_cnt = stall_cnt_q;

endmodule
